// File: rtl/axi_ar_arbiter.sv
// axi_ar_arbiter: two-master arbiter for the AXI read-address channel.
// A grant locks onto one master until its AR handshake completes. The
// granted master index is prepended to its ID so read data can be routed
// back to it.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration with
// a direct hand-over on handshake. Without it, arbitration is fixed
// priority with M0 over M1, and every handshake returns to IDLE.
module axi_ar_arbiter #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int IDS_W  = 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   ARID_M0,
  input  logic [ADDR_W-1:0] ARADDR_M0,
  input  logic [3:0]        ARLEN_M0,
  input  logic [2:0]        ARSIZE_M0,
  input  logic [1:0]        ARBURST_M0,
  input  logic              ARVALID_M0,
  output logic              ARREADY_M0,
  input  logic [ID_W-1:0]   ARID_M1,
  input  logic [ADDR_W-1:0] ARADDR_M1,
  input  logic [3:0]        ARLEN_M1,
  input  logic [2:0]        ARSIZE_M1,
  input  logic [1:0]        ARBURST_M1,
  input  logic              ARVALID_M1,
  output logic              ARREADY_M1,
  output logic [IDS_W-1:0]  ARID_S,
  output logic [ADDR_W-1:0] ARADDR_S,
  output logic [3:0]        ARLEN_S,
  output logic [2:0]        ARSIZE_S,
  output logic [1:0]        ARBURST_S,
  output logic              ARVALID_S,
  input  logic              ARREADY_S,
  output logic [1:0]        GRANT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // last = 1'b1 means M1 was granted most recently, so M0 is favoured next
  logic last;
  logic last_nxt;
  logic pick_m1;

  // Arbitration winner in IDLE: M1 wins only when it is the sole requester,
  // or, in round-robin mode, when M0 was the master served most recently
`ifdef ARB_ROUND_ROBIN_EN
  assign pick_m1 = ARVALID_M1 && (!ARVALID_M0 || !last);
`else
  assign pick_m1 = ARVALID_M1 && !ARVALID_M0;
`endif

  // State and priority pointer; reset favours M0 by marking M1 as last
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Next-state logic and the combinational forwarding of the granted master
  always_comb begin
    state_nxt  = state;
    last_nxt   = last;
    ARREADY_M0 = 1'b0;
    ARREADY_M1 = 1'b0;
    ARID_S     = '0;
    ARADDR_S   = '0;
    ARLEN_S    = '0;
    ARSIZE_S   = '0;
    ARBURST_S  = '0;
    ARVALID_S  = 1'b0;
    GRANT      = 2'b00;
    case (state)
      IDLE: begin
        if (ARVALID_M0 || ARVALID_M1) begin
          state_nxt = pick_m1 ? GNT1 : GNT0;
        end
      end
      GNT0: begin
        GRANT      = 2'b01;
        ARVALID_S  = ARVALID_M0;
        ARREADY_M0 = ARREADY_S;
        ARID_S     = IDS_W'({4'd0, ARID_M0});
        ARADDR_S   = ARADDR_M0;
        ARLEN_S    = ARLEN_M0;
        ARSIZE_S   = ARSIZE_M0;
        ARBURST_S  = ARBURST_M0;
        if (ARVALID_M0 && ARREADY_S) begin
          last_nxt = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
          state_nxt = ARVALID_M1 ? GNT1 : IDLE;
`else
          state_nxt = IDLE;
`endif
        end
      end
      GNT1: begin
        GRANT      = 2'b10;
        ARVALID_S  = ARVALID_M1;
        ARREADY_M1 = ARREADY_S;
        ARID_S     = IDS_W'({4'd1, ARID_M1});
        ARADDR_S   = ARADDR_M1;
        ARLEN_S    = ARLEN_M1;
        ARSIZE_S   = ARSIZE_M1;
        ARBURST_S  = ARBURST_M1;
        if (ARVALID_M1 && ARREADY_S) begin
          last_nxt = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          state_nxt = ARVALID_M0 ? GNT0 : IDLE;
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_ar_arbiter.sv
// tb_axi_ar_arbiter: directed self-checking bench for axi_ar_arbiter.
// Expectations follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_axi_ar_arbiter;

  logic        ACLK;
  logic        ARESETn;
  logic [3:0]  ARID_M0, ARID_M1;
  logic [31:0] ARADDR_M0, ARADDR_M1;
  logic [3:0]  ARLEN_M0, ARLEN_M1;
  logic [2:0]  ARSIZE_M0, ARSIZE_M1;
  logic [1:0]  ARBURST_M0, ARBURST_M1;
  logic        ARVALID_M0, ARVALID_M1;
  logic        ARREADY_M0, ARREADY_M1;
  logic [7:0]  ARID_S;
  logic [31:0] ARADDR_S;
  logic [3:0]  ARLEN_S;
  logic [2:0]  ARSIZE_S;
  logic [1:0]  ARBURST_S;
  logic        ARVALID_S;
  logic        ARREADY_S;
  logic [1:0]  GRANT;

  int n_cmp = 0;
  int n_err = 0;

  axi_ar_arbiter #(.ADDR_W(32), .ID_W(4), .IDS_W(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0),
    .ARSIZE_M0(ARSIZE_M0), .ARBURST_M0(ARBURST_M0),
    .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
    .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1),
    .ARSIZE_M1(ARSIZE_M1), .ARBURST_M1(ARBURST_M1),
    .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
    .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S),
    .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S), .GRANT(GRANT)
  );

  // Free-running clock, 10 time units per period
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 unit after a rising edge; outputs are sampled on the falling edge
  task automatic next_cycle();
    @(posedge ACLK);
    #1;
  endtask

  initial begin : stim
    logic [1:0] exp_grant [4];
    int vcount;
    int hcount;
    int m1_grants;

`ifdef ARB_ROUND_ROBIN_EN
    exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
`else
    exp_grant[0] = 2'b01; exp_grant[1] = 2'b00; exp_grant[2] = 2'b01; exp_grant[3] = 2'b00;
`endif

    ARID_M0 = 4'hA; ARADDR_M0 = 32'h0000_1000; ARLEN_M0 = 4'h3; ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'b01;
    ARID_M1 = 4'h5; ARADDR_M1 = 32'h0001_0040; ARLEN_M1 = 4'h7; ARSIZE_M1 = 3'd3; ARBURST_M1 = 2'b10;
    ARESETn = 1'b0; ARVALID_M0 = 1'b1; ARVALID_M1 = 1'b1; ARREADY_S = 1'b1;

    // Reset held two cycles with both masters requesting
    repeat (2) @(posedge ACLK);
    #1;
    @(negedge ACLK);
    check("rst_grant", 64'(GRANT), 64'h0);
    check("rst_arvalid_s", 64'(ARVALID_S), 64'h0);
    check("rst_arready_m0", 64'(ARREADY_M0), 64'h0);
    check("rst_arready_m1", 64'(ARREADY_M1), 64'h0);
    check("rst_arid_s", 64'(ARID_S), 64'h0);
    check("rst_araddr_s", 64'(ARADDR_S), 64'h0);

    next_cycle(); ARESETn = 1'b1;
    @(negedge ACLK);
    check("post_rst_idle", 64'(GRANT), 64'h0);

    // First arbitration after reset favours M0; handshake this cycle
    next_cycle(); ARVALID_M1 = 1'b0;
    @(negedge ACLK);
    check("first_grant", 64'(GRANT), 64'h1);
    check("first_arvalid_s", 64'(ARVALID_S), 64'h1);
    check("first_arready_m0", 64'(ARREADY_M0), 64'h1);
    check("first_arready_m1", 64'(ARREADY_M1), 64'h0);
    check("first_arid_s", 64'(ARID_S), 64'h0A);
    check("first_araddr_s", 64'(ARADDR_S), 64'h0000_1000);
    check("first_arlen_s", 64'(ARLEN_S), 64'h3);

    next_cycle(); ARVALID_M0 = 1'b0;
    @(negedge ACLK);
    check("after_hs_idle", 64'(GRANT), 64'h0);

    // Single master M1 with a slave stall of three cycles
    next_cycle(); ARVALID_M1 = 1'b1; ARREADY_S = 1'b0;
    @(negedge ACLK);
    check("m1_req_idle", 64'(GRANT), 64'h0);
    vcount = 0;
    hcount = 0;
    for (int i = 0; i < 4; i++) begin
      next_cycle(); ARREADY_S = (i == 3);
      @(negedge ACLK);
      check($sformatf("m1_grant_%0d", i), 64'(GRANT), 64'h2);
      check($sformatf("m1_arid_s_%0d", i), 64'(ARID_S), 64'h15);
      check($sformatf("m1_araddr_s_%0d", i), 64'(ARADDR_S), 64'h0001_0040);
      check($sformatf("m1_arready_m0_%0d", i), 64'(ARREADY_M0), 64'h0);
      if (ARVALID_S) vcount++;
      if (ARREADY_M1) hcount++;
    end
    check("m1_valid_cycles", 64'(vcount), 64'd4);
    check("m1_ready_pulses", 64'(hcount), 64'd1);
    check("m1_arburst_s", 64'(ARBURST_S), 64'h2);

    next_cycle(); ARVALID_M1 = 1'b0; ARREADY_S = 1'b0;
    @(negedge ACLK);
    check("m1_done_idle", 64'(GRANT), 64'h0);
    check("m1_done_arvalid_s", 64'(ARVALID_S), 64'h0);

    // Continuous contention with the slave always ready
    next_cycle(); ARVALID_M0 = 1'b1; ARVALID_M1 = 1'b1; ARREADY_S = 1'b1;
    @(negedge ACLK);
    check("cont_idle", 64'(GRANT), 64'h0);
    hcount = 0;
    m1_grants = 0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge ACLK);
      check($sformatf("cont_grant_%0d", i), 64'(GRANT), 64'(exp_grant[i]));
      if (ARVALID_S && ARREADY_S) hcount++;
      if (GRANT[1]) m1_grants++;
    end
`ifdef ARB_ROUND_ROBIN_EN
    check("cont_handshakes", 64'(hcount), 64'd4);
    check("cont_m1_grants", 64'(m1_grants), 64'd2);
`else
    check("cont_handshakes", 64'(hcount), 64'd2);
    check("cont_m1_starved", 64'(m1_grants), 64'd0);
`endif

    // Both paths end up granting M0 here; drain it and return to IDLE
    next_cycle(); ARVALID_M1 = 1'b0;
    @(negedge ACLK);
    check("drain_grant_m0", 64'(GRANT), 64'h1);
    next_cycle(); ARVALID_M0 = 1'b0;
    @(negedge ACLK);
    check("drain_idle", 64'(GRANT), 64'h0);

    // Lock: M0 granted and stalled while M1 requests
    next_cycle(); ARVALID_M0 = 1'b1; ARREADY_S = 1'b0;
    @(negedge ACLK);
    check("lock_pre_idle", 64'(GRANT), 64'h0);
    next_cycle(); ARVALID_M1 = 1'b1;
    @(negedge ACLK);
    check("lock_grant_0", 64'(GRANT), 64'h1);
    check("lock_arready_m1_0", 64'(ARREADY_M1), 64'h0);
    check("lock_arready_m0_0", 64'(ARREADY_M0), 64'h0);
    for (int i = 1; i < 3; i++) begin
      next_cycle();
      @(negedge ACLK);
      check($sformatf("lock_grant_%0d", i), 64'(GRANT), 64'h1);
      check($sformatf("lock_arready_m1_%0d", i), 64'(ARREADY_M1), 64'h0);
    end
    next_cycle(); ARREADY_S = 1'b1;
    @(negedge ACLK);
    check("lock_hs_arready_m0", 64'(ARREADY_M0), 64'h1);
    check("lock_hs_grant", 64'(GRANT), 64'h1);
    next_cycle(); ARVALID_M0 = 1'b0; ARREADY_S = 1'b0;
    @(negedge ACLK);
`ifdef ARB_ROUND_ROBIN_EN
    check("lock_handover", 64'(GRANT), 64'h2);
`else
    check("lock_handover", 64'(GRANT), 64'h0);
`endif

    // Reset while M1 is locked and stalled
    next_cycle();
    @(negedge ACLK);
    check("rmid_locked_grant", 64'(GRANT), 64'h2);
    check("rmid_locked_arready_m1", 64'(ARREADY_M1), 64'h0);
    next_cycle(); ARESETn = 1'b0;
    @(negedge ACLK);
    check("rmid_in_rst_arready_m1", 64'(ARREADY_M1), 64'h0);
    next_cycle(); ARESETn = 1'b1; ARREADY_S = 1'b1; ARVALID_M0 = 1'b1;
    @(negedge ACLK);
    check("rmid_grant_dropped", 64'(GRANT), 64'h0);
    check("rmid_arvalid_s", 64'(ARVALID_S), 64'h0);
    check("rmid_arready_m1", 64'(ARREADY_M1), 64'h0);
    next_cycle();
    @(negedge ACLK);
    check("rmid_rearb_grant", 64'(GRANT), 64'h1);
    check("rmid_rearb_arid_s", 64'(ARID_S), 64'h0A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_ar_arbiter.md
# axi_ar_arbiter

Two-master arbiter for the AXI read-address (AR) channel. It sits between masters M0 and M1 and the shared AR input of the interconnect's address decoder, granting one master at a time. A grant stays locked until that master's address handshake completes. The block widens the master ID into the slave-side ID so read data can be routed back.

## Interface
Parameters:
- ADDR_W, 32: address width (`AXI_ADDR_BITS)
- ID_W, 4: master-side ID width (`AXI_ID_BITS)
- IDS_W, 8: slave-side ID width (`AXI_IDS_BITS); must equal ID_W+4

Ports:
- ACLK  in  1  clock; all state updates on the rising edge
- ARESETn  in  1  reset, synchronous, active-low
- ARID_M0 / ARID_M1  in  ID_W  master transaction IDs
- ARADDR_M0 / ARADDR_M1  in  ADDR_W  master addresses
- ARLEN_M0 / ARLEN_M1  in  4  burst lengths
- ARSIZE_M0 / ARSIZE_M1  in  3  burst sizes
- ARBURST_M0 / ARBURST_M1  in  2  burst types
- ARVALID_M0 / ARVALID_M1  in  1  master address valids
- ARREADY_M0 / ARREADY_M1  out  1  readies returned to the masters
- ARID_S  out  IDS_W  {4'(granted index), ARID_Mx}
- ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S  out  forwarded payload
- ARVALID_S  out  1  to the decoder
- ARREADY_S  in  1  from the decoder (already slave-muxed)
- GRANT  out  2  one-hot current grant {M1,M0}; 2'b00 when idle

## Operation
- Registered state, three values:
  - IDLE
  - GNT0: locked to M0
  - GNT1: locked to M1
- Registered priority pointer `last`. It records the master granted most recently.
- IDLE:
  - All outputs are 0.
  - If any ARVALID_Mx is high, the next state is the winning master's GNTx.
  - Winner: in round-robin mode, the master that is not `last` wins when both request. In fixed mode, M0 always wins.
- GNTx:
  - ARVALID_S = ARVALID_Mx.
  - Payload is forwarded combinationally from Mx.
  - ARID_S upper 4 bits = x, zero-extended.
  - ARREADY_Mx = ARREADY_S. The other ARREADY is 0.
- Handshake (ARVALID_S & ARREADY_S in GNTx):
  - `last` <= x.
  - If the other master's ARVALID is high in the same cycle, go directly to that master's GNT state (round-robin mode only).
  - Otherwise go to IDLE.
- No handshake: stay in GNTx regardless of the other master. The grant is never preempted.
- If the granted master drops ARVALID before the handshake (protocol violation), ARVALID_S follows it low and the lock is held.
- The non-granted master sees ARREADY=0 and must hold its request; the arbiter stores no payload.

## Timing
- Reset (ARESETn=0 at a rising edge):
  - State <= IDLE; `last` <= M1, so M0 wins first.
  - All outputs 0 the next cycle, including GRANT=2'b00.
- Reset mid-transfer drops the grant immediately. No handshake is reported to any master.
- Latency: a request first seen in IDLE at edge N produces ARVALID_S high in cycle N+1.
  - Earliest handshake is cycle N+1 (ARREADY_S already high).
- Throughput:
  - Alternating contention, round-robin mode: one AR transfer per cycle.
  - Same master repeating: one transfer per 2 cycles (via IDLE).
- Simultaneous first requests from IDLE: resolved by `last` (round-robin mode) or in favour of M0 (fixed mode).
- ARREADY_S high while ARVALID_S is low has no effect.
- All outputs are combinational from the state register and inputs. No registered payload.

## Configuration
- ARB_ROUND_ROBIN_EN:
  - Defined: round-robin as described.
    - `last` is used for selection.
    - The direct GNTx→GNTy hand-over on handshake is enabled.
  - Undefined: fixed priority, M0 over M1.
    - Every handshake returns to IDLE.
    - `last` is still updated but is not used for selection.

## Test plan
- Reset with both valids high:
  - ARESETn=0 for 2 cycles → all outputs 0, GRANT=00.
  - After release with ARREADY_S=1: M0 handshakes at cycle 1, ARID_S=8'h0A for ARID_M0=4'hA.
- Single master M1, ARADDR_M1=32'h0001_0040, ARREADY_S held low 3 cycles then high:
  - GRANT=10 throughout.
  - ARVALID_S held high for 4 cycles.
  - ARREADY_M1 pulses once; ARID_S upper nibble = 1.
- Both masters valid continuously, ARREADY_S=1, round-robin mode:
  - Grants alternate M0,M1,M0,M1 on consecutive cycles.
  - 4 handshakes in 4 cycles after the first grant.
- Same stimulus, macro undefined:
  - M0 wins every arbitration; handshakes every 2 cycles.
  - M1 is starved while M0 remains valid.
- Lock test: M0 granted, ARREADY_S=0; M1 raises ARVALID:
  - GRANT stays 01, ARREADY_M1=0.
  - After the M0 handshake, GRANT=10 the next cycle.
- Reset mid-grant: M1 locked with ARREADY_S=0, ARESETn pulsed low 1 cycle:
  - No ARREADY_M1 pulse; outputs 0.
  - Next arbitration with both valid grants M0.
